regfile_write_arbiter: RTL

- Shares the register file's single write port (WE/Rd/WD) between two writers: the core writeback path (A) and a multi-cycle load/debug return path (B).
- A has absolute priority and is never stalled by default. B requests are buffered in a DEPTH-entry FIFO and drained when the port is free.
- A scoreboard query lets the core stall on registers that still have pending B writes.
- A younger A write cancels older queued B writes to the same register.

---
 rtl/regfile_write_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - shares the register-file write port between core writeback (A) and a queued load/debug path (B)
//
// Purpose: A writes pass straight to the port with zero latency. B writes are
// queued in a DEPTH-entry FIFO and drained whenever A leaves the port free. A
// younger A write kills older queued B writes to the same register. A
// scoreboard reports whether a queried register still has a live queued write.
//
// Optional feature macro: RFARB_STARVE_GUARD_EN. When defined, a wait counter
// forces one A stall after a live head has waited MAX_WAIT cycles. When not
// defined, a_stall is 0 and A always wins.
//
// Ports:
//   clk, reset                      rising-edge clock, async active-high reset
//   a_valid/a_rd/a_wd, a_stall      core writeback request, stall back to core
//   b_valid/b_rd/b_wd, b_ready      load/debug request with valid/ready handshake
//   q_rs1/q_rs2, q_hit1/q_hit2      scoreboard queries and hit flags
//   rf_we/rf_rd/rf_wd               register-file write port
//   fifo_count                      occupied FIFO slots, live or killed
module regfile_write_arbiter #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     a_valid,
  input  logic [4:0]               a_rd,
  input  logic [WIDTH-1:0]         a_wd,
  output logic                     a_stall,
  input  logic                     b_valid,
  input  logic [4:0]               b_rd,
  input  logic [WIDTH-1:0]         b_wd,
  output logic                     b_ready,
  input  logic [4:0]               q_rs1,
  input  logic [4:0]               q_rs2,
  output logic                     q_hit1,
  output logic                     q_hit2,
  output logic                     rf_we,
  output logic [4:0]               rf_rd,
  output logic [WIDTH-1:0]         rf_wd,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = PW + 1;

  logic [4:0]       q_rd [DEPTH];
  logic [WIDTH-1:0] q_wd [DEPTH];
  logic [DEPTH-1:0] q_live;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CNTW-1:0]  count;

  logic a_active, empty, full, head_live, stall, grant_a, pop, push, push_live;

  always_comb begin
    a_active  = a_valid && (a_rd != 5'd0);
    empty     = (count == '0);
    full      = (count == CNTW'(DEPTH));
    head_live = q_live[head];
  end

`ifdef RFARB_STARVE_GUARD_EN
  localparam int WW = $clog2(MAX_WAIT + 1);
  logic [WW-1:0] wait_cnt;

  // wait_cnt holds the cycles already waited, so this is the MAX_WAIT-th one.
  always_comb
    stall = !reset && a_active && head_live && (wait_cnt == WW'(MAX_WAIT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      wait_cnt <= '0;
    else if (pop || empty)
      wait_cnt <= '0;
    else if (head_live)
      wait_cnt <= wait_cnt + WW'(1);
  end
`else
  always_comb stall = 1'b0;
`endif

  always_comb begin
    grant_a   = !reset && a_active && !stall;
    // Any free port cycle retires the head; a killed head retires silently.
    pop       = !reset && !empty && !grant_a;
    b_ready   = !reset && (!full || pop);
    push      = b_valid && b_ready && (b_rd != 5'd0);
    // Same-cycle B is older than same-cycle A, so a matching A kills it too.
    push_live = !(a_active && (a_rd == b_rd));
    a_stall   = stall;
  end

  always_comb begin
    rf_we = 1'b0;
    rf_rd = 5'd0;
    rf_wd = '0;
    if (grant_a) begin
      rf_we = 1'b1;
      rf_rd = a_rd;
      rf_wd = a_wd;
    end else if (pop && head_live) begin
      rf_we = 1'b1;
      rf_rd = q_rd[head];
      rf_wd = q_wd[head];
    end
  end

  always_comb begin
    q_hit1 = 1'b0;
    q_hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_live[i] && (q_rd[i] == q_rs1) && (q_rs1 != 5'd0)) q_hit1 = 1'b1;
      if (q_live[i] && (q_rd[i] == q_rs2) && (q_rs2 != 5'd0)) q_hit2 = 1'b1;
    end
  end

  // Kill, pop and push all land on the same edge; later assignments win, so a
  // push into the slot just vacated by a pop (full case) keeps its live bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      q_live <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (a_active && q_live[i] && (q_rd[i] == a_rd)) q_live[i] <= 1'b0;
      if (pop) begin
        q_live[head] <= 1'b0;
        head         <= head + PW'(1);
      end
      if (push) begin
        q_live[tail] <= push_live;
        tail         <= tail + PW'(1);
      end
      count <= count + CNTW'(push) - CNTW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[tail] <= b_rd;
      q_wd[tail] <= b_wd;
    end
  end

  assign fifo_count = count;

endmodule
